nonzero_lane_scanner: RTL



---
 rtl/nonzero_lane_scanner_pkg.sv | 22 ++
 rtl/nonzero_lane_scanner_lnzd.sv | 48 ++++
 rtl/nonzero_lane_scanner.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/nonzero_lane_scanner_pkg.sv
// -----------------------------------------------------------------------------
// nonzero_lane_scanner_pkg
// Shared helpers for the zero-skipping lane scanner and its LNZD priority
// detector.
//   clog2(value) : ceiling log2, used to size lane-index buses at elaboration.
// -----------------------------------------------------------------------------
package nonzero_lane_scanner_pkg;

  // Ceiling log2 for elaboration-time sizing. A value of 1 yields 0, so callers
  // that need at least one index bit must guarantee a width of 2 or more.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/nonzero_lane_scanner_lnzd.sv
// -----------------------------------------------------------------------------
// LNZD
// Lowest-nonzero detector built as a radix-2 tree, LSB-first. The node with
// the lower lane indices always wins, so the position returned is that of the
// lowest set bit of data_in.
// Ports:
//   data_in  [BIT_WIDTH-1:0]        occupancy bits to search
//   position [clog2(BIT_WIDTH)-1:0] index of the lowest set bit (don't-care
//                                   when valid is 0)
//   valid                           at least one bit of data_in is set
// -----------------------------------------------------------------------------
module LNZD
  import nonzero_lane_scanner_pkg::*;
#(
  parameter int BIT_WIDTH = 16
) (
  input  logic [BIT_WIDTH-1:0]        data_in,
  output logic [clog2(BIT_WIDTH)-1:0] position,
  output logic                        valid
);

  localparam int POS_W = clog2(BIT_WIDTH);

  // Heap-ordered tree: node n has children 2n and 2n+1, leaves sit at
  // BIT_WIDTH + lane. The left child always covers the lower lanes.
  logic             node_v [1:2*BIT_WIDTH-1];
  logic [POS_W-1:0] node_p [1:2*BIT_WIDTH-1];

  // Evaluating the nodes from the leaves upward inside one block keeps the
  // whole tree a single combinational process.
  always_comb begin
    for (int n = 1; n < 2*BIT_WIDTH; n++) begin
      node_v[n] = 1'b0;
      node_p[n] = '0;
    end
    for (int i = 0; i < BIT_WIDTH; i++) begin
      node_v[BIT_WIDTH+i] = data_in[i];
      node_p[BIT_WIDTH+i] = POS_W'(i);
    end
    for (int n = BIT_WIDTH - 1; n >= 1; n--) begin
      node_v[n] = node_v[2*n] | node_v[2*n+1];
      node_p[n] = node_v[2*n] ? node_p[2*n] : node_p[2*n+1];
    end
    valid    = node_v[1];
    position = node_p[1];
  end

endmodule

// File: rtl/nonzero_lane_scanner.sv
// -----------------------------------------------------------------------------
// nonzero_lane_scanner
// Zero-skipping front end for the sparse MAC/hash datapath. Accepts one vector
// of BIT_WIDTH lanes and emits one (index, value) beat per nonzero lane,
// lowest index first. An all-zero vector produces a single marker beat.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   vector handshake; in_data lane i at
//                         in_data[i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid / out_ready beat handshake
//   out_index, out_value  lane index and value of the current nonzero lane
//   out_last              final beat of the current vector
//   out_zero              vector was all-zero (single marker beat)
// -----------------------------------------------------------------------------
module nonzero_lane_scanner
  import nonzero_lane_scanner_pkg::*;
#(
  parameter int BIT_WIDTH  = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [BIT_WIDTH*DATA_WIDTH-1:0] in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [clog2(BIT_WIDTH)-1:0]     out_index,
  output logic [DATA_WIDTH-1:0]           out_value,
  output logic                            out_last,
  output logic                            out_zero
);

  localparam int IDX_W = clog2(BIT_WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e                          state_q, state_d;
  logic [BIT_WIDTH-1:0]            mask_q, mask_d;
  logic [BIT_WIDTH*DATA_WIDTH-1:0] data_q, data_d;
  logic                            zero_q, zero_d;

  logic [IDX_W-1:0]     lnzd_pos;
  logic                 lnzd_valid;
  logic [BIT_WIDTH-1:0] load_mask;
  logic [IDX_W-1:0]     beat_index;
  logic [DATA_WIDTH-1:0] beat_value;
  logic [BIT_WIDTH-1:0] rest_mask;
  logic                 beat_last;
  logic                 scan_active;
  logic                 accept;
  logic                 transfer;

  // Lowest remaining occupied lane comes from the registered mask only, so
  // nothing on in_* can reach the beat outputs in the same cycle.
  LNZD #(
    .BIT_WIDTH (BIT_WIDTH)
  ) u_lnzd (
    .data_in  (mask_q),
    .position (lnzd_pos),
    .valid    (lnzd_valid)
  );

  assign scan_active = (state_q == SCAN);

  // Occupancy of an incoming vector: one bit per lane that has any bit set.
  always_comb begin
    load_mask = '0;
    for (int i = 0; i < BIT_WIDTH; i++) begin
      load_mask[i] = |in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Current beat: lane mux on the detected index, plus the mask that would
  // remain once this lane is consumed. An empty remainder marks the last beat;
  // an all-zero vector is its own single last beat at index 0.
  always_comb begin
    beat_index = zero_q ? '0 : lnzd_pos;
    beat_value = '0;
    rest_mask  = '0;
    for (int i = 0; i < BIT_WIDTH; i++) begin
      if (beat_index == IDX_W'(i)) begin
        beat_value = data_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
      rest_mask[i] = mask_q[i] & (beat_index != IDX_W'(i));
    end
    beat_last = zero_q | (rest_mask == '0);
  end

  // Outputs are held at zero outside SCAN so idle and reset look clean.
  assign out_valid = scan_active;
  assign out_index = scan_active ? beat_index : '0;
  assign out_value = scan_active ? beat_value : '0;
  assign out_last  = scan_active & beat_last;
  assign out_zero  = scan_active & zero_q;

  // A new vector may be taken while idle, or in the same cycle the last beat
  // of the current one leaves, which gives back-to-back vectors with no bubble.
  // rst gates it so nothing looks acceptable while reset is held.
  assign in_ready = ~rst & (~scan_active | (out_ready & beat_last));
  assign accept   = in_valid & in_ready;
  assign transfer = out_valid & out_ready;

  // Next-state logic. The load on accept is applied last because it wins
  // over the retire-to-IDLE path when a vector follows a last beat directly.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    data_d  = data_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        mask_d = '0;
      end
      SCAN: begin
        if (transfer) begin
          if (!beat_last) begin
            mask_d = rest_mask;
          end else begin
            mask_d  = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        mask_d  = '0;
      end
    endcase
    if (accept) begin
      state_d = SCAN;
      data_d  = in_data;
      mask_d  = load_mask;
      zero_d  = (load_mask == '0);
    end
  end

  // State registers; reset discards any vector in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      data_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
    end
  end

  // A nonzero vector in SCAN must always have an occupied lane left to emit.
  assert property (@(posedge clk) disable iff (rst)
                   (scan_active && !zero_q) |-> lnzd_valid);

endmodule
